// File: rtl/usram_fifo64x12.sv
//----------------------------------------------------------------------------
// Module      : usram_fifo64x12
// Description : Single-clock 64 x WIDTH first-word-fall-through FIFO built on
//               a uSRAM-style 64-entry array plus a small output pipeline.
//               Optional macro USRAM_FIFO_RDATA_REG_EN adds a registered
//               array read stage and a 2-entry skid behind the output stage.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module usram_fifo64x12 #(
    parameter int WIDTH         = 12,
    parameter int AFULL_THRESH  = 56,
    parameter int AEMPTY_THRESH = 8
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [WIDTH-1:0] W_DATA,
    input  logic             W_VALID,
    output logic             W_READY,
    output logic [WIDTH-1:0] R_DATA,
    output logic             R_VALID,
    input  logic             R_READY,
    output logic [6:0]       LEVEL,
    output logic             ALMOST_FULL,
    output logic             ALMOST_EMPTY
);

    localparam int DEPTH = 64;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [5:0]       wptr;
    logic [5:0]       rptr;
    logic             write_acc;
    logic             read_acc;
    logic             arr_nonempty;
    logic             fetch;
    logic [6:0]       level_next;

    assign write_acc  = W_VALID & W_READY;
    assign read_acc   = R_VALID & R_READY;
    // Words held in the array never reach 64 because the output stages
    // always hold at least one word once the array backs up, so pointer
    // equality is an unambiguous empty test.
    assign arr_nonempty = (wptr != rptr);
    assign level_next   = LEVEL + {6'd0, write_acc} - {6'd0, read_acc};

    // Storage array: no reset, writes ignored while reset is asserted.
    always_ff @(posedge CLK) begin
        if (Reset && write_acc) begin
            mem[wptr] <= W_DATA;
        end
    end

    // Pointers, occupancy and registered threshold flags.
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            wptr         <= 6'd0;
            rptr         <= 6'd0;
            LEVEL        <= 7'd0;
            W_READY      <= 1'b0;
            ALMOST_FULL  <= 1'b0;
            ALMOST_EMPTY <= 1'b1;
        end else begin
            if (write_acc) begin
                wptr <= wptr + 6'd1;
            end
            if (fetch) begin
                rptr <= rptr + 6'd1;
            end
            LEVEL        <= level_next;
            // A same-edge read does not free a slot for the write: the
            // ready flag only follows the updated level.
            W_READY      <= (level_next != 7'd64);
            ALMOST_FULL  <= (level_next >= 7'(AFULL_THRESH));
            ALMOST_EMPTY <= (level_next <= 7'(AEMPTY_THRESH));
        end
    end

`ifdef USRAM_FIFO_RDATA_REG_EN
    // Array read register feeding a 3-deep output queue (head + 2 skid).
    logic             pipe_valid;
    logic [WIDTH-1:0] pipe_data;
    logic [WIDTH-1:0] q_data  [3];
    logic [WIDTH-1:0] q_shift [3];
    logic [1:0]       q_cnt;
    logic [1:0]       q_mid;
    logic [1:0]       q_next;

    assign q_mid  = q_cnt - {1'b0, read_acc};
    assign q_next = q_mid + {1'b0, pipe_valid};
    // Issue an array read only if the word will find room in the queue on
    // the following edge even if the consumer stalls.
    assign fetch  = arr_nonempty & (q_next != 2'd3);
    assign R_DATA = q_data[0];

    // Next queue contents: pop the head, then append the read register.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            q_shift[i] = q_data[i];
        end
        if (read_acc) begin
            q_shift[0] = q_data[1];
            q_shift[1] = q_data[2];
        end
        for (int i = 0; i < 3; i++) begin
            if (pipe_valid && (q_mid == 2'(i))) begin
                q_shift[i] = pipe_data;
            end
        end
    end

    // Read register and output queue state.
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            pipe_valid <= 1'b0;
            pipe_data  <= '0;
            q_cnt      <= 2'd0;
            R_VALID    <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                q_data[i] <= '0;
            end
        end else begin
            pipe_valid <= fetch;
            if (fetch) begin
                pipe_data <= mem[rptr];
            end
            q_cnt   <= q_next;
            R_VALID <= (q_next != 2'd0);
            for (int i = 0; i < 3; i++) begin
                q_data[i] <= q_shift[i];
            end
        end
    end
`else
    // Refill the single output stage whenever it is empty or being drained.
    assign fetch = arr_nonempty & (~R_VALID | R_READY);

    // Single output stage loaded straight from the array.
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            R_VALID <= 1'b0;
            R_DATA  <= '0;
        end else if (fetch) begin
            R_VALID <= 1'b1;
            R_DATA  <= mem[rptr];
        end else if (read_acc) begin
            R_VALID <= 1'b0;
        end
    end
`endif

endmodule

`default_nettype wire
